// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one result bit per clock through a single carry flop.
// Results are published only on entry to DONE; partial sums stay internal.
module serial_adder_n #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_s;
  logic             bit_s;
  logic             carry_out_s;

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    accept_s    = 1'b0;
    bit_s       = 1'b0;
    carry_out_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        bit_s        = a_q[cnt_q] ^ b_q[cnt_q] ^ carry_q;
        carry_out_s  = (a_q[cnt_q] & b_q[cnt_q]) | (carry_q & (a_q[cnt_q] ^ b_q[cnt_q]));
        acc_d[cnt_q] = bit_s;
        carry_d      = carry_out_s;
        if (cnt_q == LAST_BIT) begin
          // Overflow: carry into the MSB differs from the carry out of it.
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = carry_out_s;
          ovf_d   = carry_q ^ carry_out_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (start) begin
          accept_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Subtraction is a + ~b + 1, so the carry is seeded with sub.
    if (accept_s) begin
      state_d = RUN;
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      a_d = a_d;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n: an arithmetic reference model queues expected
// results with their due cycle; a negedge monitor compares every cycle.
module tb_serial_adder_n;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         held;
  int           cyc;
  int           run_left;
  int           checks;
  int           errors;

  serial_adder_n #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic on plain integers.
  function automatic exp_t model(input int av, input int bv, input bit s);
    exp_t e;
    int   lim;
    int   sa;
    int   sb;
    int   r;
    int   sr;
    lim = 1 << W;
    sa  = (av >= lim / 2) ? av - lim : av;
    sb  = (bv >= lim / 2) ? bv - lim : bv;
    if (!s) begin
      r      = av + bv;
      sr     = sa + sb;
      e.cout = (r >= lim);
    end else begin
      r      = av - bv;
      sr     = sa - sb;
      e.cout = (av >= bv);
    end
    e.sum = W'(r & (lim - 1));
    e.ovf = (sr > lim / 2 - 1) || (sr < -(lim / 2));
    e.due = 0;
    return e;
  endfunction

  // Protocol model: start is taken whenever no operation is still running.
  initial begin
    cyc      = 0;
    run_left = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        run_left  = 0;
        held.sum  = '0;
        held.cout = 1'b0;
        held.ovf  = 1'b0;
      end else begin
        exp_t e;
        cyc = cyc + 1;
        if (start && run_left == 0) begin
          e     = model(int'(a), int'(b), sub);
          e.due = cyc + W;
          exp_q.push_back(e);
          run_left = W;
        end else if (run_left > 0) begin
          run_left = run_left - 1;
        end else begin
          run_left = 0;
        end
      end
    end
  end

  // Monitor: compare handshake and result outputs mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit exp_done;
        exp_done = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (exp_done) begin
          held = exp_q.pop_front();
        end
        checks = checks + 1;
        if (done !== exp_done) begin
          errors = errors + 1;
          $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, exp_done);
        end
        checks = checks + 1;
        if (busy !== (run_left != 0)) begin
          errors = errors + 1;
          $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, run_left != 0);
        end
        checks = checks + 1;
        if (sum !== held.sum || cout !== held.cout || ovf !== held.ovf) begin
          errors = errors + 1;
          $display("FAIL result cyc=%0d got sum=%0d cout=%b ovf=%b want sum=%0d cout=%b ovf=%b",
                   cyc, sum, cout, ovf, held.sum, held.cout, held.ovf);
        end
      end
    end
  end

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                    input bit poke);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    sub   = s;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      start = (poke && i < W - 1) ? 1'($urandom) : 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
    end
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    sub    = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(4'd3, 4'd2, 1'b0, 1'b0);
    op(4'd15, 4'd1, 1'b0, 1'b0);
    op(4'd7, 4'd1, 1'b0, 1'b0);
    op(4'd2, 4'd3, 1'b1, 1'b0);
    op(4'd8, 4'd1, 1'b1, 1'b0);
    op(4'd9, 4'd4, 1'b0, 1'b1);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge clk);
    start = 1'b1;
    a     = 4'd5;
    b     = 4'd6;
    sub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 4'd0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL async_reset got busy=%b done=%b sum=%0d cout=%b ovf=%b want all zero",
               busy, done, sum, cout, ovf);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    op(4'd1, 4'd1, 1'b0, 1'b0);

    // Start held high: back-to-back operations every W+1 cycles.
    @(negedge clk);
    start = 1'b1;
    repeat (22) begin
      @(negedge clk);
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
    end
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (W + 3) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain got %0d pending results want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; legal range 1..32.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-004 start  input  1  request to begin an operation, sampled on rising clk edge.
REQ-005 sub  input  1  mode select, sampled with start: 0 = a+b, 1 = a-b.
REQ-006 a  input  WIDTH  first operand, sampled with start.
REQ-007 b  input  WIDTH  second operand, sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking that a new result is valid.
REQ-010 sum  output  WIDTH  result of the last completed operation, modulo 2^WIDTH.
REQ-011 cout  output  1  carry out of the MSB for the last result; for sub, 1 = no borrow.
REQ-012 ovf  output  1  two's-complement signed overflow for the last result.

Function
REQ-013 The block SHALL compute one result bit per clock using a single registered carry (bit-serial ripple), not a WIDTH-bit parallel adder.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE: start=1 at an edge SHALL latch a, b (b inverted when sub=1), set carry to sub, clear the bit counter and enter RUN.
REQ-016 RUN: each edge SHALL compute bit i = a[i]^b'[i]^carry, update carry, increment the counter from 0 to WIDTH-1.
REQ-017 At the edge processing bit WIDTH-1, the FSM SHALL enter DONE and load sum, cout and ovf in the same edge.
REQ-018 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE, unless start=1 at that edge.
REQ-020 start=1 in DONE SHALL be accepted exactly as in IDLE, giving back-to-back operations with no idle cycle.
REQ-021 Latency: start accepted at edge k -> done=1 during the cycle following edge k+WIDTH.
REQ-022 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; busy and done SHALL never both be 1.
REQ-023 start while in RUN SHALL be ignored, with no effect on the running operation.
REQ-024 Changes on a, b or sub after the start edge SHALL NOT affect the operation in flight.
REQ-025 sum, cout and ovf SHALL hold their last values until the next DONE entry; partial results SHALL NOT be visible.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH)) bits, minimum 1; WIDTH=1 SHALL complete in one RUN cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, with busy=0, done=0, sum=0, cout=0, ovf=0, the counter and carry cleared.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-029 After rst_n deasserts, the first start SHALL be accepted at the first rising edge with rst_n=1.

Verification (WIDTH=4)
REQ-030 a=3, b=2, sub=0, start for 1 cycle -> busy for 4 cycles, done pulse, sum=5, cout=0, ovf=0.
REQ-031 a=15, b=1, sub=0 -> sum=0, cout=1, ovf=0; then a=7, b=1 -> sum=8, cout=0, ovf=1.
REQ-032 a=2, b=3, sub=1 -> sum=15, cout=0 (borrow), ovf=0; a=8, b=1, sub=1 -> sum=7, cout=1, ovf=1.
REQ-033 start pulsed again during RUN, with a and b changed mid-RUN -> exactly one done, result from the originally latched operands.
REQ-034 rst_n=0 for 1 cycle during the 2nd RUN cycle -> outputs 0 immediately, no done; a following start of 1+1 gives sum=2.
REQ-035 start held high continuously -> done pulses every 5 cycles, with busy low only in the done cycles.
